// File: rtl/audio_i2s_tx.sv
// I2S transmitter: FIFO-buffered mono 16-bit samples sent on both channels of a
// 32-bclk frame, with bclk/lrclk derived from clk and sticky debug flags.
module audio_i2s_tx #(
  parameter int CLK_DIV = 2,
  parameter int DEPTH   = 4,
  parameter int LVL_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [15:0]       in_data,
  input  logic              mute,
  input  logic              clr_flags,
  output logic              i2s_bclk,
  output logic              i2s_lrclk,
  output logic              i2s_data,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              overflow,
  output logic              underrun
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bit_cnt;
  logic [15:0]      last_word;
  logic [15:0]      shift_word;
  logic             out_pend;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [15:0]      mem [DEPTH];

  logic        div_wrap;
  logic        fall;
  logic [4:0]  bit_next;
  logic        load;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push;
  logic        drop;
  logic [15:0] new_last;
  logic [15:0] frame_word;

  assign div_wrap   = (div_cnt == DIV_MAX);
  assign fall       = div_wrap && i2s_bclk;
  assign bit_next   = bit_cnt + 5'd1;
  assign load       = fall && (bit_next == 5'd0);
  assign empty      = (fifo_level == '0);
  assign full       = (fifo_level == LVL_FULL);
  assign pop        = load && !empty;
  // A full FIFO still accepts a push when the frame load frees a slot in the same cycle.
  assign push       = in_valid && (!full || pop);
  assign drop       = in_valid && !push;
  assign new_last   = pop ? mem[rd_ptr] : last_word;
  assign frame_word = mute ? 16'h0000 : new_last;

  // NOTE: sample storage has no reset; emptiness is defined by the pointers and level alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      i2s_bclk   <= 1'b0;
      bit_cnt    <= 5'd31;
      last_word  <= 16'h0000;
      shift_word <= 16'h0000;
      out_pend   <= 1'b0;
      i2s_data   <= 1'b0;
      i2s_lrclk  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
      if (div_wrap) i2s_bclk <= ~i2s_bclk;
      if (fall)     bit_cnt  <= bit_next;

      if (load) begin
        last_word  <= new_last;
        shift_word <= frame_word;
      end

      // Serial outputs follow the bclk fall by one clk, using the bit index just reached.
      out_pend <= fall;
      if (out_pend) begin
        i2s_data  <= shift_word[4'd15 - bit_cnt[3:0]];
        i2s_lrclk <= (bit_cnt >= 5'd15) && (bit_cnt <= 5'd30);
      end

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase

      overflow <= drop || (overflow && !clr_flags);
      underrun <= (load && empty) || (underrun && !clr_flags);
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx: hand-timed reset/latency checks, a table of
// per-frame vectors, and sequences for full-FIFO push/pop and mid-frame reset.
module tb_audio_i2s_tx;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        mute;
  logic        clr_flags;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_data;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        underrun;

  audio_i2s_tx #(.CLK_DIV(2), .DEPTH(4), .LVL_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .mute       (mute),
    .clr_flags  (clr_flags),
    .i2s_bclk   (i2s_bclk),
    .i2s_lrclk  (i2s_lrclk),
    .i2s_data   (i2s_data),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]       n_push;
    logic [4:0][15:0] w;
    logic             clr;
    logic             mute_next;
    logic [15:0]      exp_word;
    logic [2:0]       exp_lvl;
    logic             exp_ovf;
    logic             exp_unr;
  } vec_t;

  localparam logic [31:0] LR_PATTERN = 32'h7FFF_8000;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          falls    = 0;
  int          consumed = 0;
  logic [31:0] cap_data;
  logic [31:0] cap_lr;
  vec_t        tbl [11];

  always @(negedge i2s_bclk) falls++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait for the next bclk fall, then sample data/lrclk one clk after it.
  task automatic next_bit(output logic d, output logic lr);
    int guard;
    guard = 0;
    while (falls <= consumed && guard < 64) begin
      tick();
      guard++;
    end
    if (guard >= 64) begin
      n_checks++;
      n_fail++;
      $display("FAIL bclk_timeout: no bclk fall within 64 clk");
    end
    consumed++;
    tick();
    d  = i2s_data;
    lr = i2s_lrclk;
  endtask

  task automatic cap_bits(input int from, input int to);
    logic d;
    logic lr;
    for (int n = from; n <= to; n++) begin
      next_bit(d, lr);
      cap_data[n] = d;
      cap_lr[n]   = lr;
    end
  endtask

  task automatic check_frame(input string name, input logic [15:0] exp_word);
    logic [15:0] left;
    logic [15:0] right;
    for (int n = 0; n < 16; n++) begin
      left[15-n]  = cap_data[n];
      right[15-n] = cap_data[n+16];
    end
    check({name, "_left"}, {16'h0, left}, {16'h0, exp_word});
    check({name, "_right"}, {16'h0, right}, {16'h0, exp_word});
    check({name, "_lrclk"}, cap_lr, LR_PATTERN);
  endtask

  function automatic vec_t mk(input logic [2:0] n_push, input logic [4:0][15:0] w,
                              input logic clr, input logic mute_next,
                              input logic [15:0] exp_word, input logic [2:0] exp_lvl,
                              input logic exp_ovf, input logic exp_unr);
    vec_t v;
    v.n_push    = n_push;
    v.w         = w;
    v.clr       = clr;
    v.mute_next = mute_next;
    v.exp_word  = exp_word;
    v.exp_lvl   = exp_lvl;
    v.exp_ovf   = exp_ovf;
    v.exp_unr   = exp_unr;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string nm;

    // Per-frame vectors: pushes/clr/mute applied after bit 0; flags and level checked after bit 31.
    tbl[0]  = mk(3'd5, {16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001}, 0, 0, 16'hA5C3, 3'd4, 1, 1);
    tbl[1]  = mk(3'd0, '0,                       1, 0, 16'h0001, 3'd3, 0, 0);
    tbl[2]  = mk(3'd0, '0,                       0, 0, 16'h0002, 3'd2, 0, 0);
    tbl[3]  = mk(3'd1, {64'h0, 16'h7FFF},        0, 0, 16'h0003, 3'd2, 0, 0);
    tbl[4]  = mk(3'd0, '0,                       0, 1, 16'h0004, 3'd1, 0, 0);
    tbl[5]  = mk(3'd0, '0,                       0, 0, 16'h0000, 3'd0, 0, 0);
    tbl[6]  = mk(3'd1, {64'h0, 16'h1234},        1, 0, 16'h7FFF, 3'd1, 0, 0);
    tbl[7]  = mk(3'd0, '0,                       0, 0, 16'h1234, 3'd0, 0, 0);
    tbl[8]  = mk(3'd0, '0,                       0, 0, 16'h1234, 3'd0, 0, 1);
    tbl[9]  = mk(3'd0, '0,                       1, 0, 16'h1234, 3'd0, 0, 0);
    tbl[10] = mk(3'd0, '0,                       0, 0, 16'h1234, 3'd0, 0, 1);

    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0; mute = 1'b0; clr_flags = 1'b0;
    cap_data = '0; cap_lr = '0;
    repeat (3) tick();
    check("rst_bclk",  {31'h0, i2s_bclk},   32'h0);
    check("rst_lrclk", {31'h0, i2s_lrclk},  32'h0);
    check("rst_data",  {31'h0, i2s_data},   32'h0);
    check("rst_level", {29'h0, fifo_level}, 32'h0);
    check("rst_ovf",   {31'h0, overflow},   32'h0);
    check("rst_unr",   {31'h0, underrun},   32'h0);

    // First frame: push at edge 1, first fall at edge 4, MSB visible after edge 5.
    rst = 1'b0; in_valid = 1'b1; in_data = 16'hA5C3;
    tick();
    in_valid = 1'b0;
    check("e1_level", {29'h0, fifo_level}, 32'd1);
    check("e1_bclk",  {31'h0, i2s_bclk},   32'h0);
    tick();
    check("e2_bclk",  {31'h0, i2s_bclk},   32'h1);
    tick();
    check("e3_bclk",  {31'h0, i2s_bclk},   32'h1);
    tick();
    check("e4_bclk",  {31'h0, i2s_bclk},   32'h0);
    check("e4_level", {29'h0, fifo_level}, 32'h0);
    check("e4_data",  {31'h0, i2s_data},   32'h0);
    tick();
    check("e5_msb",   {31'h0, i2s_data},   32'h1);
    check("e5_lrclk", {31'h0, i2s_lrclk},  32'h0);
    cap_data[0] = i2s_data;
    cap_lr[0]   = i2s_lrclk;
    consumed = falls;
    cap_bits(1, 31);
    check_frame("f0", 16'hA5C3);
    check("f0_unr", {31'h0, underrun}, 32'h0);

    for (int i = 0; i < 11; i++) begin
      cap_bits(0, 0);
      for (int k = 0; k < int'(tbl[i].n_push); k++) begin
        in_valid = 1'b1;
        in_data  = tbl[i].w[k];
        tick();
      end
      in_valid = 1'b0;
      if (tbl[i].clr) begin
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
      end
      mute = tbl[i].mute_next;
      cap_bits(1, 31);
      nm = $sformatf("f%0d", i + 1);
      check_frame(nm, tbl[i].exp_word);
      check({nm, "_level"}, {29'h0, fifo_level}, {29'h0, tbl[i].exp_lvl});
      check({nm, "_ovf"},   {31'h0, overflow},   {31'h0, tbl[i].exp_ovf});
      check({nm, "_unr"},   {31'h0, underrun},   {31'h0, tbl[i].exp_unr});
    end

    // Fill to four, then push exactly on the frame-load edge.
    cap_bits(0, 0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 16'hB001 + 16'(k);
      tick();
    end
    in_valid = 1'b0;
    cap_bits(1, 31);
    check_frame("f12", 16'h1234);
    check("f12_level", {29'h0, fifo_level}, 32'd4);
    tick();
    tick();
    in_valid = 1'b1; in_data = 16'hCAFE;
    tick();
    in_valid = 1'b0;
    check("full_pop_align", falls, consumed + 1);
    check("full_pop_level", {29'h0, fifo_level}, 32'd4);
    check("full_pop_ovf",   {31'h0, overflow},   32'h0);
    for (int f = 0; f < 5; f++) begin
      cap_bits(0, 31);
      check_frame($sformatf("fp%0d", f), (f < 4) ? 16'hB001 + 16'(f) : 16'hCAFE);
    end
    check("fp_end_level", {29'h0, fifo_level}, 32'h0);

    // Reset in the middle of the right channel.
    cap_bits(0, 0);
    in_valid = 1'b1; in_data = 16'h5555;
    tick();
    in_valid = 1'b0;
    cap_bits(1, 20);
    check("pre_rst_lrclk", {31'h0, i2s_lrclk},  32'h1);
    check("pre_rst_level", {29'h0, fifo_level}, 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_bclk",  {31'h0, i2s_bclk},   32'h0);
    check("mid_rst_lrclk", {31'h0, i2s_lrclk},  32'h0);
    check("mid_rst_data",  {31'h0, i2s_data},   32'h0);
    check("mid_rst_level", {29'h0, fifo_level}, 32'h0);
    check("mid_rst_unr",   {31'h0, underrun},   32'h0);
    rst = 1'b0; clr_flags = 1'b1;
    consumed = falls;
    repeat (3) tick();
    check("restart_e3_bclk", {31'h0, i2s_bclk}, 32'h1);
    check("restart_e3_nofall", falls, consumed);
    tick();
    check("restart_e4_bclk", {31'h0, i2s_bclk}, 32'h0);
    check("restart_e4_fall", falls, consumed + 1);
    check("set_beats_clr",   {31'h0, underrun}, 32'h1);
    clr_flags = 1'b0;
    consumed = falls;
    tick();
    check("restart_e5_data",  {31'h0, i2s_data},   32'h0);
    check("restart_e5_lrclk", {31'h0, i2s_lrclk},  32'h0);
    check("restart_e5_level", {29'h0, fifo_level}, 32'h0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("clr_unr", {31'h0, underrun}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
